// File: rtl/mole_scheduler.sv
// Whack-A-Mole game sequencer: picks holes from the RNG, times each mole's
// up-window against the tick strobe, and tallies hits and misses.
module mole_scheduler #(
  parameter int IDX_W      = 2,
  parameter int UP_TICKS   = 100,
  parameter int GAP_BASE   = 20,
  parameter int MAX_MISSES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [7:0]           rnd,
  input  logic [2**IDX_W-1:0]  btn,
  output logic [2**IDX_W-1:0]  mole,
  output logic [7:0]           score,
  output logic [3:0]           misses,
  output logic                 game_over,
  output logic                 rnd_used
);

  localparam int NUM_MOLES = 2**IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    GAP  = ST_GAP,
    UP   = ST_UP,
    OVER = ST_OVER
  } state_t;

  localparam logic [7:0]           UP_LOAD    = 8'(UP_TICKS);
  localparam logic [7:0]           GAP_LOAD   = 8'(GAP_BASE);
  localparam logic [3:0]           MISS_LIMIT = 4'(MAX_MISSES);
  localparam logic [NUM_MOLES-1:0] NO_MOLE    = {NUM_MOLES{1'b0}};

  function automatic logic [NUM_MOLES-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_MOLES-1:0] v;
    v    = NO_MOLE;
    v[i] = 1'b1;
    return v;
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     prev_idx_q, prev_idx_d;
  logic [NUM_MOLES-1:0] mole_q, mole_d;
  logic [7:0]           score_q, score_d;
  logic [3:0]           misses_q, misses_d;
  logic                 game_over_q, game_over_d;
  logic                 rnd_used_q, rnd_used_d;

  logic [7:0]       gap_load_s;
  logic [7:0]       cnt_dec_s;
  logic [IDX_W-1:0] pick_s;
  logic [3:0]       misses_inc_s;
  logic             expire_s;
  logic             hit_s;
  logic             unused_rnd_bits;

  // Gap length, hole choice with repeat avoidance, and interval expiry.
  always_comb begin
    gap_load_s   = GAP_LOAD + {4'd0, rnd[7:4]};
    cnt_dec_s    = tick ? (cnt_q - 8'd1) : cnt_q;
    expire_s     = tick && (cnt_q == 8'd1);
    hit_s        = btn[prev_idx_q];
    misses_inc_s = misses_q + 4'd1;
    if (rnd[IDX_W-1:0] == prev_idx_q) begin
      pick_s = rnd[IDX_W-1:0] + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      pick_s = rnd[IDX_W-1:0];
    end
  end

  assign unused_rnd_bits = ^rnd;

  // Game FSM: next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_idx_d  = prev_idx_q;
    mole_d      = mole_q;
    score_d     = score_q;
    misses_d    = misses_q;
    game_over_d = game_over_q;
    rnd_used_d  = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        mole_d = NO_MOLE;
        if (start) begin
          state_d     = GAP;
          score_d     = 8'd0;
          misses_d    = 4'd0;
          game_over_d = 1'b0;
          cnt_d       = gap_load_s;
          rnd_used_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      GAP: begin
        mole_d = NO_MOLE;
        if (expire_s) begin
          prev_idx_d = pick_s;
          mole_d     = onehot(pick_s);
          cnt_d      = UP_LOAD;
          rnd_used_d = 1'b1;
          state_d    = UP;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      UP: begin
        // A hit on the expiring tick still counts as a hit.
        if (hit_s) begin
          score_d    = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
          mole_d     = NO_MOLE;
          cnt_d      = gap_load_s;
          rnd_used_d = 1'b1;
          state_d    = GAP;
        end else if (expire_s) begin
          misses_d = misses_inc_s;
          mole_d   = NO_MOLE;
          if (misses_inc_s == MISS_LIMIT) begin
            game_over_d = 1'b1;
            state_d     = OVER;
          end else begin
            cnt_d      = gap_load_s;
            rnd_used_d = 1'b1;
            state_d    = GAP;
          end
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      default: begin
        state_d     = IDLE;
        mole_d      = NO_MOLE;
        game_over_d = 1'b0;
        cnt_d       = 8'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any game in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      prev_idx_q  <= {IDX_W{1'b0}};
      mole_q      <= NO_MOLE;
      score_q     <= 8'd0;
      misses_q    <= 4'd0;
      game_over_q <= 1'b0;
      rnd_used_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_idx_q  <= prev_idx_d;
      mole_q      <= mole_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      game_over_q <= game_over_d;
      rnd_used_q  <= rnd_used_d;
    end
  end

  assign mole      = mole_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = game_over_q;
  assign rnd_used  = rnd_used_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed scoreboard bench for mole_scheduler: expected outputs are queued as
// each step is driven and checked #1 after the clock edge that produces them.
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rnd = 8'h00;
  logic [3:0] btn = 4'h0;
  logic [3:0] mole;
  logic [7:0] score;
  logic [3:0] misses;
  logic       game_over;
  logic       rnd_used;

  mole_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .rnd(rnd), .btn(btn),
    .mole(mole), .score(score), .misses(misses), .game_over(game_over),
    .rnd_used(rnd_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   prev_i;
  int   nxt;

  task automatic expect_out(input string tag, input logic [3:0] m, input logic [7:0] s,
                            input logic [3:0] mi, input logic g, input logic u);
    exp_t e;
    e.tag = tag;
    e.v   = {m, s, mi, g, u};
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t        e;
    logic [17:0] got;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e   = sb.pop_front();
      got = {mole, score, misses, game_over, rnd_used};
      assert (got === e.v) else begin
        bad++;
        $error("FAIL %s: got mole=%b score=%0d misses=%0d game_over=%b rnd_used=%b, expected mole=%b score=%0d misses=%0d game_over=%b rnd_used=%b",
               e.tag, got[17:14], got[13:6], got[5:2], got[1], got[0],
               e.v[17:14], e.v[13:6], e.v[5:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic drive(input logic tk, input logic st, input logic [7:0] r, input logic [3:0] b);
    tick  = tk;
    start = st;
    rnd   = r;
    btn   = b;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
    rnd   = 8'h00;
    btn   = 4'h0;
  endtask

  task automatic ticks(input int n, input logic [7:0] r);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, r, 4'h0);
  endtask

  task automatic step(input string tag, input logic tk, input logic st, input logic [7:0] r,
                      input logic [3:0] b, input logic [3:0] m, input logic [7:0] s,
                      input logic [3:0] mi, input logic g, input logic u);
    expect_out(tag, m, s, mi, g, u);
    drive(tk, st, r, b);
    compare();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 4'h0, 8'd0, 4'd0, 1'b0, 1'b0);
    compare();
    rst = 1'b1;

    // Start: gap = 20 + 3 = 23 ticks.
    step("start",      1'b0, 1'b1, 8'h35, 4'h0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b1);
    step("ru_pulse",   1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b0);
    ticks(21, 8'h02);
    step("gap_early",  1'b1, 1'b0, 8'h02, 4'h0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b0);
    step("first_mole", 1'b1, 1'b0, 8'h02, 4'h0, 4'b0100, 8'd0, 4'd0, 1'b0, 1'b1);
    step("wrong_btn",  1'b0, 1'b0, 8'h00, 4'b0001, 4'b0100, 8'd0, 4'd0, 1'b0, 1'b0);
    step("start_in_up", 1'b0, 1'b1, 8'h00, 4'h0, 4'b0100, 8'd0, 4'd0, 1'b0, 1'b0);
    // Hit, gap = 20 + 5 = 25.
    step("hit",        1'b0, 1'b0, 8'h50, 4'b0100, 4'h0, 8'd1, 4'd0, 1'b0, 1'b1);
    step("btn_in_gap", 1'b1, 1'b0, 8'h02, 4'hF, 4'h0, 8'd1, 4'd0, 1'b0, 1'b0);
    ticks(23, 8'h02);
    step("repeat_2",   1'b1, 1'b0, 8'h02, 4'h0, 4'b1000, 8'd1, 4'd0, 1'b0, 1'b1);
    step("hit2",       1'b0, 1'b0, 8'h00, 4'b1000, 4'h0, 8'd2, 4'd0, 1'b0, 1'b1);
    ticks(19, 8'h03);
    step("repeat_3",   1'b1, 1'b0, 8'h03, 4'h0, 4'b0001, 8'd2, 4'd0, 1'b0, 1'b1);

    // Three timeouts end the game.
    ticks(98, 8'h00);
    step("up_99",      1'b1, 1'b0, 8'h00, 4'h0, 4'b0001, 8'd2, 4'd0, 1'b0, 1'b0);
    step("miss1",      1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 8'd2, 4'd1, 1'b0, 1'b1);
    ticks(19, 8'h01);
    step("mole_b",     1'b1, 1'b0, 8'h01, 4'h0, 4'b0010, 8'd2, 4'd1, 1'b0, 1'b1);
    ticks(99, 8'h00);
    step("miss2",      1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 8'd2, 4'd2, 1'b0, 1'b1);
    ticks(19, 8'h02);
    step("mole_c",     1'b1, 1'b0, 8'h02, 4'h0, 4'b0100, 8'd2, 4'd2, 1'b0, 1'b1);
    ticks(99, 8'h00);
    step("miss3",      1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 8'd2, 4'd3, 1'b1, 1'b0);
    step("over_hold",  1'b1, 1'b0, 8'h00, 4'hF, 4'h0, 8'd2, 4'd3, 1'b1, 1'b0);
    step("restart",    1'b0, 1'b1, 8'h00, 4'h0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b1);

    // Hit on the expiring tick wins over the miss.
    ticks(19, 8'h01);
    step("mole_d",     1'b1, 1'b0, 8'h01, 4'h0, 4'b0010, 8'd0, 4'd0, 1'b0, 1'b1);
    ticks(99, 8'h00);
    step("hit_at_expiry", 1'b1, 1'b0, 8'h00, 4'b0010, 4'h0, 8'd1, 4'd0, 1'b0, 1'b1);

    // Score saturation: hole choices avoid repeats so the pick equals rnd[1:0].
    prev_i = 1;
    for (int k = 0; k < 253; k++) begin
      nxt = (prev_i + 1) % 4;
      ticks(19, 8'h00);
      drive(1'b1, 1'b0, 8'(nxt), 4'h0);
      drive(1'b0, 1'b0, 8'h00, 4'(1 << nxt));
      prev_i = nxt;
    end
    nxt = (prev_i + 1) % 4;
    ticks(19, 8'h00);
    drive(1'b1, 1'b0, 8'(nxt), 4'h0);
    step("hit_255",    1'b0, 1'b0, 8'h00, 4'(1 << nxt), 4'h0, 8'd255, 4'd0, 1'b0, 1'b1);
    prev_i = nxt;
    nxt = (prev_i + 1) % 4;
    ticks(19, 8'h00);
    drive(1'b1, 1'b0, 8'(nxt), 4'h0);
    step("hit_sat",    1'b0, 1'b0, 8'h00, 4'(1 << nxt), 4'h0, 8'd255, 4'd0, 1'b0, 1'b1);
    prev_i = nxt;
    nxt = (prev_i + 1) % 4;
    ticks(19, 8'h00);
    step("mole_pre_rst", 1'b1, 1'b0, 8'(nxt), 4'h0, 4'(1 << nxt), 8'd255, 4'd0, 1'b0, 1'b1);

    // Asynchronous reset between clock edges.
    #3;
    rst = 1'b0;
    #1;
    expect_out("async_rst", 4'h0, 8'd0, 4'd0, 1'b0, 1'b0);
    compare();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("idle_after_rst", 1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b0);
    ticks(30, 8'h02);
    step("idle_no_start",  1'b1, 1'b0, 8'h02, 4'hF, 4'h0, 8'd0, 4'd0, 1'b0, 1'b0);
    step("resume",         1'b0, 1'b1, 8'h00, 4'h0, 4'h0, 8'd0, 4'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Game-sequencing controller for Whack-A-Mole.
- Consumes the free-running 8-bit RNG value `rnd` to choose which hole raises a mole and how long the gap before it lasts.
- Times each mole's up-window, detects hits from debounced button pulses, and keeps score and miss count.
- Sits between the RNG, the tick divider, the button debouncers and the LED/7-seg display logic.

Parameters:
- IDX_W, 2, hole index width; NUM_MOLES = 2**IDX_W holes.
- UP_TICKS, 100, ticks a mole stays up before counting as a miss (range 1..255).
- GAP_BASE, 20, minimum ticks between moles; the actual gap is GAP_BASE + rnd[7:4] (range 1..239).
- MAX_MISSES, 3, number of misses that ends the game (range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- tick  in  1  one-cycle timebase strobe from the divider.
- start  in  1  one-cycle start/restart pulse.
- rnd  in  8  current RNG output.
- btn  in  NUM_MOLES  debounced one-cycle press pulses, one bit per hole.
- mole  out  NUM_MOLES  one-hot lit hole; all zero when no mole is up.
- score  out  8  hit count, saturating.
- misses  out  4  miss count.
- game_over  out  1  high in OVER.
- rnd_used  out  1  one-cycle pulse in every cycle `rnd` is sampled.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; mole=0, score=0, misses=0, game_over=0, rnd_used=0.
  - Internal counter=0, prev_idx=0.
  - Reset mid-game aborts immediately with no residual outputs.
- All outputs are registered. `mole` changes one cycle after the event that causes it.
- Counter rule: load N, decrement only on cycles with tick=1. Expiry is the tick cycle on which the counter equals 1, so the interval is exactly N ticks.
- IDLE:
  - start=1 -> GAP.
  - Same cycle: score=0, misses=0, game_over=0, counter=GAP_BASE+rnd[7:4], rnd_used=1.
- GAP:
  - mole=0.
  - On expiry: idx=rnd[IDX_W-1:0]. If idx==prev_idx, use idx+1 (mod NUM_MOLES).
  - mole=one-hot(idx), prev_idx=idx, counter=UP_TICKS, rnd_used=1 -> UP.
  - btn ignored.
- UP:
  - Hit: btn[idx]=1 -> score=min(score+1,255), mole=0, counter=GAP_BASE+rnd[7:4], rnd_used=1 -> GAP.
  - Wrong-hole presses are ignored. A hit is recognised if btn has the correct bit set, even when other bits are also set.
  - Timeout: on expiry without a hit -> misses=misses+1, mole=0.
    - If the new misses==MAX_MISSES -> OVER.
    - Else load the gap counter (rnd_used=1) -> GAP.
  - Hit and expiry in the same cycle: hit wins; misses unchanged.
- OVER:
  - game_over=1, mole=0; score and misses held.
  - start=1 -> same action as from IDLE (game_over clears next cycle).
- start is ignored in GAP and UP.
- tick and btn asserted in the same cycle are both honoured per the rules above.
- rnd is sampled only in the cycles where rnd_used=1. rnd_used is 0 otherwise.
- States are encoded as localparams. Illegal states recover to IDLE.

Test Plan:
- Reset/start:
  - Apply rst=0 for 2 cycles -> all outputs 0.
  - rst=1, rnd=8'h35, start pulse -> rnd_used=1 that cycle; GAP counter = 20+3 = 23.
  - After 23 ticks with rnd=8'h02 -> mole=4'b0100 and rnd_used pulses.
- Hit path:
  - With mole=4'b0100, pulse btn=4'b0100 -> score=1 and mole=0 next cycle, state GAP.
  - Pulse btn=4'b0001 while a mole is up -> no change.
- Repeat avoidance:
  - Previous idx=2, rnd[1:0]=2 at gap expiry -> mole=4'b1000.
  - Previous idx=3, rnd[1:0]=3 -> mole=4'b0001.
- Miss/game over:
  - Let 3 moles time out after 100 ticks each, with no presses -> misses=1,2,3 and game_over=1 after the third.
  - mole stays 0; a further tick changes nothing.
  - start -> game_over=0, score=0, misses=0.
- Simultaneous and saturation:
  - btn[idx] on the same cycle as the expiring tick -> score+1, misses unchanged.
  - Preload score to 255 via 255 hits, then one more hit -> score stays 255.
- Async reset mid-UP:
  - Drop rst between clock edges -> mole=0 immediately, before the next clk edge.
  - State IDLE; start is required to resume play.
